// File: rtl/sort5_pipe.sv
// Pipelined 5-input sorting network (9 compare-exchanges, 5 registered layers) with valid/ready flow control.
// Optional SORT5_TAG_EN adds tag_0..tag_4 carrying each element's original input index.
module sort5_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_desc,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic [DATA_W-1:0] data_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sort_0,
  output logic [DATA_W-1:0] sort_1,
  output logic [DATA_W-1:0] sort_2,
  output logic [DATA_W-1:0] sort_3,
  output logic [DATA_W-1:0] sort_4,
  output logic              out_desc
`ifdef SORT5_TAG_EN
  ,
  output logic [2:0]        tag_0,
  output logic [2:0]        tag_1,
  output logic [2:0]        tag_2,
  output logic [2:0]        tag_3,
  output logic [2:0]        tag_4
`endif
);

  typedef logic [4:0][DATA_W-1:0] word_t;
  typedef logic [4:0][2:0]        tags_t;

  localparam tags_t LANE_TAGS = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  // Handshake: a word enters when in_valid && in_ready, leaves when out_valid && out_ready;
  // the whole pipe moves together whenever the output stage is empty or being drained.
  logic       w_adv;
  word_t      w_q     [5];
  logic [4:0] w_qv;
  logic [4:0] w_qdesc;
`ifdef SORT5_TAG_EN
  tags_t      w_qt    [5];
`endif

  function automatic logic cx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic desc);
    cx = desc ? (a < b) : (a > b);
  endfunction

  assign w_adv    = !w_qv[4] || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam logic [2:0] PA0 = (k == 3) ? 3'd1 : (k == 4) ? 3'd2 : 3'd0;
    localparam logic [2:0] PB0 = (k == 0) ? 3'd3 : (k == 1) ? 3'd2 : (k == 2) ? 3'd1 :
                                 (k == 3) ? 3'd2 : 3'd3;
    localparam logic [2:0] PA1 = (k <= 1) ? 3'd1 : (k == 2) ? 3'd2 : 3'd3;
    localparam logic [2:0] PB1 = (k == 1) ? 3'd3 : 3'd4;

    word_t r_d;
    logic  r_v;
    logic  r_desc;
    word_t w_src;
    word_t w_res;
    logic  w_v_in;
    logic  w_desc_in;
    logic  w_sw0;
    logic  w_sw1;

    if (k == 0) begin : g_src
      assign w_src     = {data_4, data_3, data_2, data_1, data_0};
      assign w_v_in    = in_valid;
      assign w_desc_in = in_desc;
    end else begin : g_src
      assign w_src     = w_q[k-1];
      assign w_v_in    = w_qv[k-1];
      assign w_desc_in = w_qdesc[k-1];
    end

    // The last layer has a single compare pair; its second swap is tied off.
    assign w_sw0 = cx(w_src[PA0], w_src[PB0], w_desc_in);
    assign w_sw1 = (k != 4) && cx(w_src[PA1], w_src[PB1], w_desc_in);

    always_comb begin
      w_res = w_src;
      if (w_sw0) begin
        w_res[PA0] = w_src[PB0];
        w_res[PB0] = w_src[PA0];
      end
      if (w_sw1) begin
        w_res[PA1] = w_src[PB1];
        w_res[PB1] = w_src[PA1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d    <= '0;
        r_v    <= 1'b0;
        r_desc <= 1'b0;
      end else if (w_adv) begin
        r_d    <= w_res;
        r_v    <= w_v_in;
        r_desc <= w_desc_in;
      end
    end

    assign w_q[k]     = r_d;
    assign w_qv[k]    = r_v;
    assign w_qdesc[k] = r_desc;

`ifdef SORT5_TAG_EN
    tags_t r_t;
    tags_t w_tsrc;
    tags_t w_tres;

    if (k == 0) begin : g_tsrc
      assign w_tsrc = LANE_TAGS;
    end else begin : g_tsrc
      assign w_tsrc = w_qt[k-1];
    end

    always_comb begin
      w_tres = w_tsrc;
      if (w_sw0) begin
        w_tres[PA0] = w_tsrc[PB0];
        w_tres[PB0] = w_tsrc[PA0];
      end
      if (w_sw1) begin
        w_tres[PA1] = w_tsrc[PB1];
        w_tres[PB1] = w_tsrc[PA1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_t <= LANE_TAGS;
      end else if (w_adv) begin
        r_t <= w_tres;
      end
    end

    assign w_qt[k] = r_t;
`endif
  end

  assign out_valid = w_qv[4];
  assign out_desc  = w_qdesc[4];
  assign sort_0    = w_q[4][0];
  assign sort_1    = w_q[4][1];
  assign sort_2    = w_q[4][2];
  assign sort_3    = w_q[4][3];
  assign sort_4    = w_q[4][4];

`ifdef SORT5_TAG_EN
  assign tag_0 = w_qt[4][0];
  assign tag_1 = w_qt[4][1];
  assign tag_2 = w_qt[4][2];
  assign tag_3 = w_qt[4][3];
  assign tag_4 = w_qt[4][4];
`endif

endmodule

// File: tb/tb_sort5_pipe.sv
// Bench for sort5_pipe: directed latency/tie/backpressure/bubble/reset steps plus a random soak,
// all scored against a bubble-sort reference model. Tag checks compile in with SORT5_TAG_EN.
module tb_sort5_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_desc;
  logic [W-1:0]  din [5];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sort_o [5];
  logic          out_desc;
`ifdef SORT5_TAG_EN
  logic [2:0]    tag_o [5];
`endif

  sort5_pipe #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
    .data_0(din[0]), .data_1(din[1]), .data_2(din[2]), .data_3(din[3]), .data_4(din[4]),
    .out_valid(out_valid), .out_ready(out_ready),
    .sort_0(sort_o[0]), .sort_1(sort_o[1]), .sort_2(sort_o[2]), .sort_3(sort_o[3]),
    .sort_4(sort_o[4]), .out_desc(out_desc)
`ifdef SORT5_TAG_EN
    , .tag_0(tag_o[0]), .tag_1(tag_o[1]), .tag_2(tag_o[2]), .tag_3(tag_o[3]), .tag_4(tag_o[4])
`endif
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_out   = 0;
  logic [5*W:0]     exp_q[$];
  logic [5*W-1:0]   in_q[$];
  logic             s_ov, s_ir, s_acc, s_del;
  logic [5*W:0]     s_out;
  logic [14:0]      s_tag;
  logic             p_stall = 1'b0;
  logic [5*W+1:0]   p_hold;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain bubble sort in the requested direction; result packed {desc, s0..s4}.
  function automatic logic [5*W:0] model_sort(input logic [5*W-1:0] w, input logic desc);
    logic [W-1:0] a [5];
    logic [W-1:0] t;
    for (int i = 0; i < 5; i++) a[i] = w[i*W +: W];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return {desc, a[0], a[1], a[2], a[3], a[4]};
  endfunction

  function automatic logic [5*W:0] cur_out();
    return {out_desc, sort_o[0], sort_o[1], sort_o[2], sort_o[3], sort_o[4]};
  endfunction

  function automatic logic [5*W-1:0] cur_in();
    return {din[4], din[3], din[2], din[1], din[0]};
  endfunction

  // One clock: sample mid-cycle, score the handshakes, then step past the rising edge.
  task automatic tick();
    logic [5*W-1:0] w;
    logic [4:0]     seen;
    logic           ok;
    @(negedge clk);
    s_ov  = out_valid;
    s_ir  = in_ready;
    s_out = cur_out();
    s_del = out_valid && out_ready;
    s_acc = in_valid && in_ready && !rst;
`ifdef SORT5_TAG_EN
    s_tag = {tag_o[0], tag_o[1], tag_o[2], tag_o[3], tag_o[4]};
`else
    s_tag = '0;
`endif
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (p_stall && !rst) check("stall_hold", {out_valid, s_out}, p_hold);
    p_stall = out_valid && !out_ready && !rst;
    p_hold  = {out_valid, s_out};
    if (s_del) begin
      n_out++;
      check("out_has_input", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("sorted_word", s_out, exp_q.pop_front());
        w = in_q.pop_front();
`ifdef SORT5_TAG_EN
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (tag_o[i] > 3'd4) ok = 1'b0;
          else begin
            if (seen[tag_o[i]]) ok = 1'b0;
            seen[tag_o[i]] = 1'b1;
            if (w[tag_o[i]*W +: W] !== sort_o[i]) ok = 1'b0;
          end
        end
        check("tag_consistency", ok, 1'b1);
`else
        seen = '0;
        ok   = (w != '1) || (seen == '0);
`endif
      end
    end
    if (s_acc) begin
      exp_q.push_back(model_sort(cur_in(), in_desc));
      in_q.push_back(cur_in());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [W-1:0] a, b, c, d, e, input logic desc);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d; din[4] = e;
    in_desc = desc;
  endtask

  task automatic set_rand_word(input int maxv);
    for (int i = 0; i < 5; i++)
      din[i] = (maxv < 0) ? $urandom() : W'($urandom_range(0, maxv));
    in_desc = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_data_desc"}, cur_out(), '0);
`ifdef SORT5_TAG_EN
    check({tag, "_tags"}, {tag_o[0], tag_o[1], tag_o[2], tag_o[3], tag_o[4]},
          {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  logic [W-1:0] bw [10][5];
  logic [W-1:0] held_bp;
  logic [5*W:0] held_out;
  int           idx, c, n0, n_acc;
  logic         pending;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_word('0, '0, '0, '0, '0, 1'b0);
    held_bp = '0;

    // Reset state, during and after release.
    #2;
    check_reset_state("rst_hold");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("rst_release");

    // Reset mid-stream with three words in flight; none may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      set_rand_word(-1);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    in_q.delete();
    check_reset_state("rst_midstream");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_no_ghost", s_ov, 1'b0);
    end

    // Ascending word, exact 5-cycle latency.
    set_word(32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 1'b0);
    in_valid = 1'b1;
    tick();
    check("asc_accept", s_acc, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("asc_latency", s_ov, i == 5);
      if (i == 5) begin
        check("asc_value", s_out, {1'b0, 32'd1, 32'd3, 32'd5, 32'd7, 32'd9});
`ifdef SORT5_TAG_EN
        check("asc_tags", s_tag, {3'd3, 3'd1, 3'd4, 3'd2, 3'd0});
`endif
      end
    end

    // Descending with ties, then an all-equal ascending word back-to-back.
    set_word(32'd4, 32'd4, 32'd0, 32'hFFFF_FFFF, 32'd4, 1'b1);
    in_valid = 1'b1;
    tick();
    set_word(32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("b2b_valid", s_ov, (i == 4) || (i == 5));
      if (i == 4) check("desc_ties", s_out, {1'b1, 32'hFFFF_FFFF, 32'd4, 32'd4, 32'd4, 32'd0});
      if (i == 5) check("equal_word", s_out, {1'b0, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2});
    end

    // Backpressure: 10 random words, out_ready low for cycles 7..10.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 5; j++) bw[i][j] = $urandom();
    idx = 0; c = 0; n0 = n_out;
    while ((idx < 10 || exp_q.size() != 0) && c < 60) begin
      in_valid = (idx < 10);
      if (idx < 10) set_word(bw[idx][0], bw[idx][1], bw[idx][2], bw[idx][3], bw[idx][4], idx[0]);
      out_ready = !(c >= 7 && c <= 10);
      tick();
      if (c >= 7 && c <= 10) begin
        check("bp_in_ready_low", s_ir, 1'b0);
        check("bp_not_accepted", s_acc, 1'b0);
        if (c == 7) held_out = s_out;
        else check("bp_out_held", s_out, held_out);
      end
      if (s_acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_count", n_out - n0, 10);

    // Throughput with bubbles on cycles 2 and 5+.
    for (int k = 0; k < 12; k++) begin
      in_valid = (k == 0) || (k == 1) || (k == 3) || (k == 4);
      set_rand_word(-1);
      tick();
      check("bubble_valid", s_ov, (k == 5) || (k == 6) || (k == 8) || (k == 9));
    end
    in_valid = 1'b0;

    // Random soak: 8-bit value range (frequent ties), random mode and random out_ready.
    n_acc = 0; c = 0; pending = 1'b0; n0 = n_out;
    while ((n_acc < 10000 || exp_q.size() != 0) && c < 60000) begin
      if (!pending && n_acc < 10000 && $urandom_range(0, 9) < 8) begin
        set_rand_word(255);
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (s_acc) begin
        pending = 1'b0;
        n_acc++;
      end
      c++;
    end
    in_valid = 1'b0;
    check("soak_accepted", n_acc, 10000);
    check("soak_delivered", n_out - n0, 10000);
    check("soak_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort5_pipe.md
# sort5_pipe

Pipelined, parametrised successor to the combinational 5-input sorter. It implements the same 9-comparator, 5-layer sorting network with a register after every layer, a configurable data width and a per-word ascending/descending mode. A valid/ready handshake with full backpressure lets it sit directly in a streaming datapath between a producer and a consumer. It accepts one 5-element word per cycle and returns it sorted a fixed 5 cycles later when not stalled.

## Interface

Parameters:
- `DATA_W`, default 32: width of each element, unsigned compare; legal range 1..64.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: input word present.
- `in_ready` out 1: block accepts input this cycle.
- `in_desc` in 1: 0 = ascending, 1 = descending; sampled with the word.
- `data_0`..`data_4` in DATA_W each: unsorted elements.
- `out_valid` out 1: sorted word present.
- `out_ready` in 1: consumer accepts output.
- `sort_0`..`sort_4` out DATA_W each: sorted elements. Ascending mode gives sort_0 ≤ … ≤ sort_4; descending mode gives sort_0 ≥ … ≥ sort_4.

## Operation

- Network layers use fixed compare pairs:
  - L0: (0,3),(1,4)
  - L1: (0,2),(1,3)
  - L2: (0,1),(2,4)
  - L3: (1,2),(3,4)
  - L4: (2,3)
- Lanes not named in a layer pass through unchanged.
- Compare-exchange (a = lower lane, b = higher lane):
  - Ascending: swap when a > b.
  - Descending: swap when a < b.
  - Equal values never swap.
- Each layer's outputs are registered into stage k, k = 0..4. Every stage holds a 5×DATA_W data register, a valid bit and a desc bit.
- Stage 4 drives `sort_*`, `out_valid` and the exported mode.
- Advance enable `adv = !out_valid || out_ready`.
  - When `adv` = 1, all stages shift one position together, and stage 0 captures the input. Its valid bit is set to `in_valid`.
  - When `adv` = 0, every stage holds its contents.
- `in_ready = adv`, which is purely combinational from stage-4 valid and `out_ready`.
- A word is accepted on a cycle where `in_valid && in_ready` holds. A word is delivered on a cycle where `out_valid && out_ready` holds.
- Bubbles (`in_valid` = 0 while `adv` = 1) propagate as invalid stages. Bubbles are not squeezed out.
- The mode is per word. Alternating `in_desc` on back-to-back words is legal, and each word is sorted by its own mode.
- Compare is unsigned on the full DATA_W bits.

## Timing

- Latency is exactly 5 cycles from acceptance to `out_valid`, given `out_ready` held 1 throughout.
- Throughput is 1 word per cycle when `out_ready` = 1.
- Stall behaviour:
  - While `out_valid && !out_ready`, the outputs are held stable, and data and valid must not change.
  - `in_ready` = 0 during a stall. Input presented during a stall is not accepted, and the producer must hold it.
- Reset, applied asynchronously:
  - All valid bits clear, so `out_valid` = 0.
  - All data registers clear to 0, so `sort_*` = 0, and desc bits = 0.
  - `in_ready` = 1 during and after reset, because `out_valid` = 0.
- Reset mid-stream discards every in-flight word. No word is delivered after reset deasserts unless it was accepted after the deassertion.
- When `out_ready` rises in the same cycle as `in_valid`, the head word is delivered and the new word is accepted in that same edge.
- Critical path is one comparator plus one 2:1 mux per stage.

## Configuration

- `SORT5_TAG_EN`:
  - Defined: adds outputs `tag_0`..`tag_4`, 3 bits each. `tag_i` gives the original input index (0..4) of the element on `sort_i`. Tags travel through the network with their data, swapping exactly when the data swaps. Tags reset to `{0,1,2,3,4}` in lane order.
  - Undefined: the tag ports and registers do not exist. Behaviour is otherwise identical.

## Test plan

- **Reset state:** assert `rst` mid-stream with 3 words in flight, then release. Required: `out_valid` = 0, `sort_*` = 0, `in_ready` = 1, and none of the 3 words ever appears.
- **Ascending, DATA_W = 32:**
  - Input (9,3,7,1,5), desc = 0, accepted at cycle t. Required: `out_valid` at t+5 with (1,3,5,7,9).
  - With tags enabled, the required tags are (3,1,4,2,0).
- **Descending plus ties:**
  - Input (4,4,0,FFFFFFFF,4), desc = 1. Required: (FFFFFFFF,4,4,4,0).
  - Back-to-back with a next word (2,2,2,2,2), desc = 0. Required: (2,2,2,2,2) at the very next cycle.
- **Backpressure:**
  - Stream 10 random words and drop `out_ready` for 4 cycles mid-stream. Required:
    - `in_ready` = 0 for those 4 cycles.
    - Outputs are held constant.
    - All 10 words emerge in order, each sorted, with none lost or duplicated.
- **Throughput and bubbles:**
  - Assert `in_valid` on cycles 0,1,3,4 with `out_ready` = 1. Required: `out_valid` on cycles 5,6,8,9 and low on cycle 7.
- **Random soak, DATA_W = 8:**
  - 10,000 words with random `in_desc` and random `out_ready`. Required:
    - Every output is an ordered permutation of its input, checked against a scoreboard.
    - Order matches the output's mode.
    - With tags enabled, each tag set is a permutation of 0..4 consistent with the data.
